// File: rtl/l2_pkg.sv
// Shared definitions for the L2 lookup/replacement controller.
// Holds the command opcode enum, the controller FSM state enum and the
// default geometry constants used by the controller and the PLRU helper.
package l2_pkg;

  localparam int L2_WAYS       = 8;
  localparam int L2_INDEX_BITS = 14;
  localparam int L2_TAG_BITS   = 10;

  typedef enum logic [1:0] {
    OP_READ       = 2'd0,
    OP_WRITE      = 2'd1,
    OP_INVALIDATE = 2'd2,
    OP_SNOOP      = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_COMPARE = 3'd2,
    ST_FILL    = 3'd3,
    ST_UPDATE  = 3'd4
  } state_e;

endpackage

// File: rtl/l2_plru.sv
// Tree pseudo-LRU helper, purely combinational.
// Ports:
//   plru      - WAYS-1 tree bits of the set (node n has children 2n+1, 2n+2;
//               0 = victim lies left, 1 = victim lies right)
//   valid     - per-way valid bits
//   touch_way - way being accessed
//   victim    - lowest invalid way if any, otherwise the tree-PLRU way
//   plru_next - tree bits with every node on touch_way's path pointing away
module l2_plru #(
  parameter int WAYS = 8
) (
  input  logic [WAYS-2:0]         plru,
  input  logic [WAYS-1:0]         valid,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [$clog2(WAYS)-1:0] victim,
  output logic [WAYS-2:0]         plru_next
);

  localparam int WB = $clog2(WAYS);

  always_comb begin
    int  node;
    logic found;
    victim = '0;
    found  = 1'b0;
    node   = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = WB'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      // Walk root to leaf following the tree bits; leaves start at WAYS-1.
      for (int l = 0; l < WB; l++) node = 2 * node + 1 + int'(plru[node]);
      victim = WB'(node - (WAYS - 1));
    end
  end

  always_comb begin
    int node;
    plru_next = plru;
    node      = int'(touch_way) + WAYS - 1;
    // Climb leaf to root; a left child (odd index) makes its parent point right.
    for (int l = 0; l < WB; l++) begin
      plru_next[(node - 1) / 2] = (node % 2 == 1);
      node = (node - 1) / 2;
    end
  end

endmodule

// File: rtl/l2_cache_ctrl.sv
// L2 tag lookup/replacement controller. One command at a time: tag read,
// parallel compare, victim selection, tag/PLRU write-back and line fill.
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while idle.
// Ports:
//   cmd_valid/cmd_ready/cmd_op/cmd_addr - command input (tag in addr MSBs)
//   tag_rd_en/tag_index                 - tag array read (1-cycle latency)
//   tag_rd_tag/tag_rd_vld/tag_rd_plru   - tag array read data
//   tag_wr_*                            - tag/valid/PLRU write for the set
//   bus_req/bus_addr/bus_ack            - line-fill request on the shared bus
//   rsp_valid/rsp_hit/rsp_way/rsp_err   - one-cycle response
//   fsm_state                           - current FSM state (debug)
module l2_cache_ctrl
  import l2_pkg::*;
#(
  parameter int WAYS       = L2_WAYS,
  parameter int INDEX_BITS = L2_INDEX_BITS,
  parameter int TAG_BITS   = L2_TAG_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [TAG_BITS+INDEX_BITS-1:0] cmd_addr,
  output logic                           tag_rd_en,
  output logic [INDEX_BITS-1:0]          tag_index,
  input  logic [WAYS*TAG_BITS-1:0]       tag_rd_tag,
  input  logic [WAYS-1:0]                tag_rd_vld,
  input  logic [WAYS-2:0]                tag_rd_plru,
  output logic                           tag_wr_en,
  output logic [$clog2(WAYS)-1:0]        tag_wr_way,
  output logic [TAG_BITS-1:0]            tag_wr_tag,
  output logic                           tag_wr_vld,
  output logic [WAYS-2:0]                tag_wr_plru,
  output logic                           bus_req,
  output logic [TAG_BITS+INDEX_BITS-1:0] bus_addr,
  input  logic                           bus_ack,
  output logic                           rsp_valid,
  output logic                           rsp_hit,
  output logic [$clog2(WAYS)-1:0]        rsp_way,
  output logic                           rsp_err,
  output state_e                         fsm_state
);

  localparam int WB = $clog2(WAYS);

  state_e                state;
  cmd_op_e               op_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [INDEX_BITS-1:0] index_q;
  logic [WAYS-2:0]       plru_q;
  logic [WB-1:0]         victim_q;

  logic [WAYS-1:0] hit;
  logic [WB-1:0]   hit_way;
  logic            any_hit;
  logic            multi_hit;
  logic [WAYS-2:0] plru_in;
  logic [WB-1:0]   touch_way;
  logic [WB-1:0]   victim;
  logic [WAYS-2:0] plru_next;

  assign tag_index = index_q;
  assign bus_addr  = {tag_q, index_q};
  assign fsm_state = state;

  // Parallel compare; lowest matching way wins, any second match flags an error.
  always_comb begin
    hit       = '0;
    hit_way   = '0;
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit[w] = tag_rd_vld[w] && (tag_rd_tag[w*TAG_BITS +: TAG_BITS] == tag_q);
      if (hit[w]) begin
        if (!any_hit) hit_way = WB'(w);
        else          multi_hit = 1'b1;
        any_hit = 1'b1;
      end
    end
  end

  // During COMPARE the live read data is touched at the hit way; during FILL
  // the latched PLRU is touched at the latched victim.
  assign plru_in   = (state == ST_COMPARE) ? tag_rd_plru : plru_q;
  assign touch_way = (state == ST_COMPARE) ? hit_way : victim_q;

  l2_plru #(.WAYS(WAYS)) u_plru (
    .plru      (plru_in),
    .valid     (tag_rd_vld),
    .touch_way (touch_way),
    .victim    (victim),
    .plru_next (plru_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_READ;
      tag_q       <= '0;
      index_q     <= '0;
      plru_q      <= '0;
      victim_q    <= '0;
      cmd_ready   <= 1'b1;
      tag_rd_en   <= 1'b0;
      tag_wr_en   <= 1'b0;
      tag_wr_way  <= '0;
      tag_wr_tag  <= '0;
      tag_wr_vld  <= 1'b0;
      tag_wr_plru <= '0;
      bus_req     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_way     <= '0;
      rsp_err     <= 1'b0;
    end else begin
      // Pulse outputs default low; rsp_* stay zero outside rsp_valid.
      tag_rd_en <= 1'b0;
      tag_wr_en <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op_e'(cmd_op);
            tag_q     <= cmd_addr[INDEX_BITS +: TAG_BITS];
            index_q   <= cmd_addr[INDEX_BITS-1:0];
            cmd_ready <= 1'b0;
            tag_rd_en <= 1'b1;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: state <= ST_COMPARE;
        ST_COMPARE: begin
          plru_q   <= tag_rd_plru;
          victim_q <= victim;
          state    <= ST_UPDATE;
          case (op_q)
            OP_READ, OP_WRITE: begin
              if (any_hit) begin
                tag_wr_en   <= 1'b1;
                tag_wr_way  <= hit_way;
                tag_wr_tag  <= tag_q;
                tag_wr_vld  <= 1'b1;
                tag_wr_plru <= plru_next;
                rsp_valid   <= 1'b1;
                rsp_hit     <= 1'b1;
                rsp_way     <= hit_way;
                rsp_err     <= multi_hit;
              end else begin
                bus_req <= 1'b1;
                state   <= ST_FILL;
              end
            end
            OP_INVALIDATE: begin
              rsp_valid <= 1'b1;
              rsp_hit   <= any_hit;
              rsp_way   <= hit_way;
              rsp_err   <= multi_hit;
              if (any_hit) begin
                tag_wr_en   <= 1'b1;
                tag_wr_way  <= hit_way;
                tag_wr_tag  <= tag_q;
                tag_wr_vld  <= 1'b0;
                tag_wr_plru <= tag_rd_plru;
              end
            end
            default: begin
              rsp_valid <= 1'b1;
              rsp_hit   <= any_hit;
              rsp_way   <= hit_way;
              rsp_err   <= multi_hit;
            end
          endcase
        end
        ST_FILL: begin
          if (bus_ack) begin
            bus_req     <= 1'b0;
            tag_wr_en   <= 1'b1;
            tag_wr_way  <= victim_q;
            tag_wr_tag  <= tag_q;
            tag_wr_vld  <= 1'b1;
            tag_wr_plru <= plru_next;
            rsp_valid   <= 1'b1;
            rsp_way     <= victim_q;
            state       <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          cmd_ready   <= 1'b1;
          tag_wr_way  <= '0;
          tag_wr_tag  <= '0;
          tag_wr_vld  <= 1'b0;
          tag_wr_plru <= '0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Testbench for l2_cache_ctrl: a tag-array model answering reads, a
// per-command reference model building the expected cycle-by-cycle outputs,
// one compare process on the falling edge, and directed literal checks.
module tb_l2_cache_ctrl;
  import l2_pkg::*;

  localparam int WAYS = L2_WAYS;
  localparam int IB   = L2_INDEX_BITS;
  localparam int TB   = L2_TAG_BITS;
  localparam int WB   = $clog2(WAYS);
  localparam int AW   = TB + IB;

  typedef struct packed {
    logic            ready, rd_en, wr_en, breq, rv, rhit, rerr;
    logic [WB-1:0]   rway, wway;
    logic [TB-1:0]   wtag;
    logic            wvld;
    logic [WAYS-2:0] wplru;
    logic [IB-1:0]   index;
    logic [AW-1:0]   baddr;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clk, rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic                 cmd_valid, cmd_ready, tag_rd_en, tag_wr_en, tag_wr_vld;
  logic [1:0]           cmd_op;
  logic [AW-1:0]        cmd_addr, bus_addr;
  logic [IB-1:0]        tag_index;
  logic [WAYS*TB-1:0]   tag_rd_tag;
  logic [WAYS-1:0]      tag_rd_vld;
  logic [WAYS-2:0]      tag_rd_plru, tag_wr_plru;
  logic [WB-1:0]        tag_wr_way, rsp_way;
  logic [TB-1:0]        tag_wr_tag;
  logic                 bus_req, bus_ack, rsp_valid, rsp_hit, rsp_err;
  state_e               fsm_state;

  l2_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .tag_rd_en(tag_rd_en), .tag_index(tag_index),
    .tag_rd_tag(tag_rd_tag), .tag_rd_vld(tag_rd_vld), .tag_rd_plru(tag_rd_plru),
    .tag_wr_en(tag_wr_en), .tag_wr_way(tag_wr_way), .tag_wr_tag(tag_wr_tag),
    .tag_wr_vld(tag_wr_vld), .tag_wr_plru(tag_wr_plru),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_err(rsp_err),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  obs_t exp_q[$];

  // Model of the tag storage for sets 0..15 (only those are addressed).
  logic [TB-1:0]   m_tag [16][WAYS];
  logic [WAYS-1:0] m_vld [16];
  logic [WAYS-2:0] m_plru[16];

  // Values seen on the DUT, for the directed literal checks.
  int            rsp_cnt = 0, wr_cnt = 0, rsp_cyc = 0;
  logic [WB-1:0] last_rway, last_wway;
  logic          last_rhit, last_rerr, last_wvld;
  logic [WAYS-2:0] last_wplru;
  logic [AW-1:0] last_baddr;

  task automatic check_obs(input string name, input obs_t a, input obs_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, a, e);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  function automatic obs_t idle_rec();
    obs_t r = '0;
    r.ready = 1'b1;
    return r;
  endfunction

  // Tree PLRU by range bisection: node 0 spans all ways, each bit halves it.
  function automatic int plru_victim(input logic [WAYS-2:0] p);
    int lo = 0, hi = WAYS, node = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (p[node]) begin lo = mid; node = 2 * node + 2; end
      else         begin hi = mid; node = 2 * node + 1; end
    end
    return lo;
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] p, input int w);
    int lo = 0, hi = WAYS, node = 0, mid;
    logic [WAYS-2:0] r = p;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin r[node] = 1'b1; node = 2 * node + 1; hi = mid; end
      else         begin r[node] = 1'b0; node = 2 * node + 2; lo = mid; end
    end
    return r;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      cyc++;
      a = {cmd_ready, tag_rd_en, tag_wr_en, bus_req, rsp_valid, rsp_hit, rsp_err,
           rsp_way, tag_wr_way, tag_wr_tag, tag_wr_vld, tag_wr_plru, tag_index, bus_addr};
      if (a.rv) begin
        rsp_cnt++; rsp_cyc = cyc;
        last_rway = a.rway; last_rhit = a.rhit; last_rerr = a.rerr;
      end
      if (a.wr_en) begin
        wr_cnt++; last_wway = a.wway; last_wvld = a.wvld; last_wplru = a.wplru;
      end
      if (a.breq) last_baddr = a.baddr;
      if (!rst_n) begin
        check_obs("reset_state", a, idle_rec());
      end else begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
        if (!(e.rd_en || e.wr_en)) begin a.index = '0; e.index = '0; end
        if (!e.wr_en) begin
          a.wway = '0; a.wtag = '0; a.wvld = 1'b0; a.wplru = '0;
          e.wway = '0; e.wtag = '0; e.wvld = 1'b0; e.wplru = '0;
        end
        if (!e.breq) begin a.baddr = '0; e.baddr = '0; end
        check_obs("cycle", a, e);
      end
    end
  end

  // ---------------- tag array model ----------------
  initial begin
    logic       rd;
    logic [3:0] ri;
    tag_rd_tag = '0; tag_rd_vld = '0; tag_rd_plru = '0;
    forever begin
      @(negedge clk);
      rd = tag_rd_en;
      ri = tag_index[3:0];
      @(posedge clk);
      #1;
      if (rd) begin
        for (int w = 0; w < WAYS; w++) tag_rd_tag[w*TB +: TB] = m_tag[ri][w];
        tag_rd_vld  = m_vld[ri];
        tag_rd_plru = m_plru[ri];
      end else begin
        // Garbage outside the read-data cycle must not influence the DUT.
        for (int w = 0; w < WAYS; w++) tag_rd_tag[w*TB +: TB] = TB'($urandom);
        tag_rd_vld  = WAYS'($urandom);
        tag_rd_plru = (WAYS-1)'($urandom);
      end
    end
  end

  // ---------------- driver ----------------
  int acc_cyc;

  // Issue one command; called at posedge+1 while the DUT is idle.
  task automatic run_cmd(input logic [1:0] op, input logic [TB-1:0] tg, input logic [3:0] idx,
                         input int d, input bit abort);
    logic [AW-1:0]   addr;
    logic [WAYS-2:0] p;
    int   nh, first, inv, vic, last;
    bit   fill, ok, r_s;
    obs_t base, r, c;
    addr = {tg, 10'b0, idx};
    p = m_plru[idx];
    nh = 0; first = 0; inv = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (m_vld[idx][w] && m_tag[idx][w] == tg) begin
        if (nh == 0) first = w;
        nh++;
      end
      if (!m_vld[idx][w] && inv < 0) inv = w;
    end
    vic  = (inv >= 0) ? inv : plru_victim(p);
    fill = (op <= 2'd1) && (nh == 0);
    base = '0;
    r = base; r.rv = 1'b1; r.index = IB'(idx);
    if (op <= 2'd1) begin
      r.wr_en = 1'b1; r.wtag = tg; r.wvld = 1'b1;
      if (nh > 0) begin
        r.rhit = 1'b1; r.rway = WB'(first); r.rerr = (nh > 1);
        r.wway = WB'(first); r.wplru = plru_touch(p, first);
      end else begin
        r.rway = WB'(vic); r.wway = WB'(vic); r.wplru = plru_touch(p, vic);
      end
    end else begin
      r.rhit = (nh > 0); r.rway = WB'(first); r.rerr = (nh > 1);
      if (op == 2'd2 && nh > 0) begin
        r.wr_en = 1'b1; r.wway = WB'(first); r.wtag = tg; r.wvld = 1'b0; r.wplru = p;
      end
    end

    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk); r_s = cmd_ready;
      @(posedge clk); ok = r_s;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: cmd_ready never seen high within 20 cycles");
      cmd_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    c = base; c.rd_en = 1'b1; c.index = IB'(idx); exp_q.push_back(c);
    exp_q.push_back(base);
    if (fill || abort) begin
      for (int k = 0; k <= (abort ? 5 : d); k++) begin
        c = base; c.breq = 1'b1; c.baddr = addr; exp_q.push_back(c);
      end
    end
    if (!abort) exp_q.push_back(r);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = AW'($urandom);

    if (abort) begin
      int rc, wc;
      bus_ack = 1'b0;
      repeat (4) @(posedge clk);
      rc = rsp_cnt; wc = wr_cnt;
      #3 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_val("abort_bus_req", 32'(bus_req), 32'd0);
      check_val("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk); @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("abort_no_rsp", 32'(rsp_cnt), 32'(rc));
      check_val("abort_no_write", 32'(wr_cnt), 32'(wc));
      return;
    end

    last = fill ? 4 + d : 3;
    for (int k = 1; k <= last; k++) begin
      if (fill) bus_ack = (k == 3 + d) ? 1'b1 : (k < 3 ? 1'($urandom) : 1'b0);
      else      bus_ack = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus_ack = 1'b0;
    // Commit the modelled update to the storage model.
    if (r.wr_en) begin
      m_tag[idx][r.wway] = r.wtag;
      m_vld[idx][r.wway] = r.wvld;
      m_plru[idx]        = r.wplru;
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [WAYS-1:0] v, input logic [WAYS-2:0] p);
    for (int w = 0; w < WAYS; w++) m_tag[idx][w] = TB'(10'h200 + w);
    m_vld[idx]  = v;
    m_plru[idx] = p;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wc;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; bus_ack = 1'b0;
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < WAYS; w++) m_tag[s][w] = TB'($urandom_range(0, 3));
      m_vld[s]  = WAYS'($urandom);
      m_plru[s] = (WAYS-1)'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_fsm_idle", 32'(fsm_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // READ hit in way 3.
    preload(4'd5, 8'b0000_1000, 7'h00);
    m_tag[5][3] = 10'h00A;
    run_cmd(2'd0, 10'h00A, 4'd5, 0, 1'b0);
    check_val("hit_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
    check_val("hit_way", 32'(last_rway), 32'd3);
    check_val("hit_flag", 32'(last_rhit), 32'd1);
    check_val("hit_plru", 32'(last_wplru), 32'h01);

    // READ miss, all valid, PLRU all zero, ack 5 cycles into the fill.
    preload(4'd6, 8'hFF, 7'h00);
    run_cmd(2'd0, 10'h055, 4'd6, 5, 1'b0);
    check_val("miss_latency", 32'(rsp_cyc - acc_cyc), 32'd9);
    check_val("miss_bus_addr", 32'(last_baddr), 32'h154006);
    check_val("miss_way", 32'(last_rway), 32'd0);
    check_val("miss_hit", 32'(last_rhit), 32'd0);

    // WRITE miss with way 2 invalid: victim way 2 regardless of PLRU.
    preload(4'd7, 8'b1111_1011, 7'h7F);
    run_cmd(2'd1, 10'h066, 4'd7, 2, 1'b0);
    check_val("invalid_victim", 32'(last_wway), 32'd2);

    // INVALIDATE hit way 5, then SNOOP hit way 2.
    preload(4'd8, 8'hFF, 7'h55);
    m_tag[8][5] = 10'h0AA;
    m_tag[8][2] = 10'h0BB;
    run_cmd(2'd2, 10'h0AA, 4'd8, 0, 1'b0);
    check_val("inval_way", 32'(last_wway), 32'd5);
    check_val("inval_vld", 32'(last_wvld), 32'd0);
    check_val("inval_plru", 32'(last_wplru), 32'h55);
    wc = wr_cnt;
    run_cmd(2'd3, 10'h0BB, 4'd8, 0, 1'b0);
    check_val("snoop_hit", 32'(last_rhit), 32'd1);
    check_val("snoop_way", 32'(last_rway), 32'd2);
    check_val("snoop_no_write", 32'(wr_cnt), 32'(wc));

    // Duplicate tag in ways 1 and 6.
    preload(4'd9, 8'b0100_0010, 7'h00);
    m_tag[9][1] = 10'h0CC;
    m_tag[9][6] = 10'h0CC;
    run_cmd(2'd0, 10'h0CC, 4'd9, 0, 1'b0);
    check_val("multi_err", 32'(last_rerr), 32'd1);
    check_val("multi_way", 32'(last_rway), 32'd1);

    // Spurious bus_ack while idle.
    wc = rsp_cnt;
    bus_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus_ack = 1'b0;
    check_val("idle_ack_ignored", 32'(rsp_cnt), 32'(wc));

    // Reset during FILL.
    preload(4'd10, 8'hFF, 7'h00);
    run_cmd(2'd0, 10'h3FF, 4'd10, 0, 1'b1);

    // Randomized traffic on a few small sets with a small tag pool.
    for (int n = 0; n < 200; n++) begin
      run_cmd(2'($urandom_range(0, 3)), TB'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              $urandom_range(0, 4), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        bus_ack = 1'($urandom);
        @(posedge clk); #1;
      end
      bus_ack = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_cache_ctrl.md
# l2_cache_ctrl

Lookup/replacement controller for the L2 cache. It accepts one command at a time and sequences a single-ported tag array across `WAYS` ways: tag read, parallel tag compare and hit detection, victim selection, and tag/pseudo-LRU write-back. On a miss it requests a line fill on the shared bus. It sits between the command/snoop front end and the per-way tag storage.

## Interface
- `WAYS`, 8: associativity; power of 2, minimum 2.
- `INDEX_BITS`, 14: set index width.
- `TAG_BITS`, 10: tag width; `cmd_addr` is `TAG_BITS+INDEX_BITS` wide, with the tag in the MSBs.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake; a command transfers when both are high.
- `cmd_op`  in  2  0 = READ, 1 = WRITE, 2 = INVALIDATE, 3 = SNOOP.
- `cmd_addr`  in  TAG_BITS+INDEX_BITS  command address.
- `tag_rd_en`  out  1  tag-array read strobe.
- `tag_index`  out  INDEX_BITS  set index for both read and write.
- `tag_rd_tag`  in  WAYS*TAG_BITS  stored tags; way w occupies bits [w*TAG_BITS +: TAG_BITS].
- `tag_rd_vld`  in  WAYS  valid bit per way.
- `tag_rd_plru`  in  WAYS-1  PLRU tree bits for the set.
- `tag_wr_en`  out  1  write strobe for tag, valid and PLRU of the set.
- `tag_wr_way`  out  log2(WAYS)  way whose tag/valid are written.
- `tag_wr_tag`  out  TAG_BITS  tag to write.
- `tag_wr_vld`  out  1  valid bit to write.
- `tag_wr_plru`  out  WAYS-1  new PLRU bits for the set.
- `bus_req`  out  1  line-fill request; held until acknowledged.
- `bus_addr`  out  TAG_BITS+INDEX_BITS  fill address (the latched `cmd_addr`).
- `bus_ack`  in  1  fill complete.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_hit`  out  1  lookup hit.
- `rsp_way`  out  log2(WAYS)  way that hit or was filled.
- `rsp_err`  out  1  multiple ways matched.

## Operation
- FSM states: IDLE, LOOKUP, COMPARE, FILL, UPDATE.
- IDLE: `cmd_ready` = 1. On handshake, latch op and address, then go to LOOKUP.
- LOOKUP: `tag_rd_en` = 1 for exactly one cycle, with `tag_index` = latched index. The tag array has a fixed 1-cycle read latency.
- COMPARE: compute `hit[w] = tag_rd_vld[w] & (tag_rd_tag[w] == latched tag)`.
  - `rsp_way` is the lowest-indexed matching way.
  - `rsp_err` = 1 if more than one way matches.
  - Latch `tag_rd_plru`.
- Victim selection: the lowest-indexed invalid way if any exists; otherwise the tree-PLRU way.
- Tree-PLRU encoding:
  - Node n has children 2n+1 and 2n+2.
  - Bit = 0 means the victim lies left; bit = 1 means right.
  - On access to way w, every node on w's path is set to point away from w.
- Transitions out of COMPARE:
  - READ/WRITE hit: UPDATE. Touch PLRU; rewrite the same tag with valid = 1.
  - READ/WRITE miss: FILL. Assert `bus_req` with `bus_addr`.
  - INVALIDATE hit: UPDATE. Write valid = 0; PLRU unchanged.
  - INVALIDATE miss: UPDATE. No write.
  - SNOOP: UPDATE. No write; PLRU unchanged.
- FILL: hold `bus_req` until the cycle `bus_ack` = 1, then go to UPDATE. In UPDATE, write the victim way with the new tag and valid = 1, touch the victim in PLRU, and report `rsp_way` = victim with `rsp_hit` = 0.
- UPDATE: `tag_wr_en` is asserted only where specified above. `rsp_valid` = 1 for one cycle, then return to IDLE.
- `bus_ack` outside FILL is ignored.

## Timing
- Reset: state = IDLE. All outputs are 0 except `cmd_ready` = 1. Latched tag/index/PLRU registers are cleared.
- Taking the accept edge as cycle 0:
  - Hit and no-op responses: `tag_rd_en` in cycle 1, compare in cycle 2, `rsp_valid` and any write in cycle 3.
  - Miss: `bus_req` from cycle 3. If `bus_ack` arrives in cycle k, then `rsp_valid` and the tag write occur in cycle k+1.
- `cmd_ready` = 0 from cycle 1 until the cycle after `rsp_valid`. Back-to-back hits therefore accept one command every 4 cycles.
- `tag_wr_en` and `rsp_valid` are coincident and single-cycle.
- `bus_req` and `bus_addr` are stable while waiting.
- Reset asserted mid-operation aborts the command immediately: no tag write, no response, `bus_req` drops.
- `rsp_*` fields are valid only while `rsp_valid` = 1; otherwise they are 0.

## Structure
- Shared package `l2_pkg`:
  - `cmd_op` enum (READ/WRITE/INVALIDATE/SNOOP).
  - FSM state enum.
  - Default constants WAYS/INDEX_BITS/TAG_BITS.
- Sub-module `l2_plru`: purely combinational, parameterised by WAYS. Inputs: plru bits, valid vector, touched way. Outputs: victim way, updated plru bits.
- The controller holds the FSM, the latch registers and the compare/priority logic.

## Test plan
- READ to address 0x00A_0005 with way 3 holding tag 0x00A, valid → `tag_rd_en` in cycle 1; `rsp_valid`, `rsp_hit` = 1, `rsp_way` = 3, and `tag_wr_en` in cycle 3; `tag_wr_plru` points away from way 3.
- READ miss on a set with all ways valid and plru = 7'b0000000 → `bus_req` with `bus_addr` = cmd_addr. `bus_ack` 5 cycles later → next cycle writes way 0 and returns `rsp_way` = 0, `rsp_hit` = 0.
- WRITE miss on a set where ways 0–1 are valid and way 2 is invalid → fill; victim = way 2 regardless of PLRU.
- INVALIDATE hit way 5 → `tag_wr_vld` = 0, `tag_wr_way` = 5, PLRU bits unchanged. SNOOP hit → response only, `tag_wr_en` never asserted.
- Tag matches in ways 1 and 6 → `rsp_err` = 1, `rsp_way` = 1. Spurious `bus_ack` in IDLE → no effect.
- Reset pulsed while in FILL → `bus_req` falls asynchronously; no `tag_wr_en` or `rsp_valid`; `cmd_ready` = 1 after release.
